// File: rtl/updown_pkg.sv
// Shared encodings for the up/down modulus counter: count direction and limit mode.
package updown_pkg;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  typedef enum int {
    MODE_WRAP = 0,
    MODE_SAT  = 1
  } mode_e;

endpackage

// File: rtl/updown_mod_counter.sv
// Cascadable up/down counter over 0..MAX with wrap or saturate behaviour at the limits,
// registered carry/borrow/saturate pulses and a combinational terminal count for chaining.
module updown_mod_counter
  import updown_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             CLK,
  input  logic             MRn,
  input  logic             SCLR,
  input  logic             NoLoad,
  input  logic             EN,
  input  logic             Dn,
  input  logic             CI,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] MAX,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             BO,
  output logic             SAT,
  output logic             TC
);

  localparam bit HOLD_AT_LIMIT = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] q_q, q_d;
  logic             co_q, co_d;
  logic             bo_q, bo_d;
  logic             sat_q, sat_d;
  logic             step;
  logic             dir_down;

  assign step     = EN & CI;
  assign dir_down = (Dn == DIR_DN);

  // Flags default low so every edge that is not the triggering step clears them.
  always_comb begin
    q_d   = q_q;
    co_d  = 1'b0;
    bo_d  = 1'b0;
    sat_d = 1'b0;
    if (SCLR) begin
      q_d = '0;
    end else if (!NoLoad) begin
      q_d = D;
    end else if (step) begin
      if (!dir_down) begin
        // ">=" so an out-of-range load still terminates an up count.
        if (q_q >= MAX) begin
          if (HOLD_AT_LIMIT) begin
            q_d   = MAX;
            sat_d = 1'b1;
          end else begin
            q_d  = '0;
            co_d = 1'b1;
          end
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (q_q == '0) begin
          if (HOLD_AT_LIMIT) begin
            sat_d = 1'b1;
          end else begin
            q_d  = MAX;
            bo_d = 1'b1;
          end
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge MRn) begin
    if (!MRn) begin
      q_q   <= '0;
      co_q  <= 1'b0;
      bo_q  <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      co_q  <= co_d;
      bo_q  <= bo_d;
      sat_q <= sat_d;
    end
  end

  assign Q   = q_q;
  assign CO  = co_q;
  assign BO  = bo_q;
  assign SAT = sat_q;
  assign TC  = step & (dir_down ? (q_q == '0) : (q_q >= MAX));

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: wrap and saturate instances against a behavioural model,
// directed literal scenarios, a two-stage decimal cascade, then randomized traffic.
module tb_updown_mod_counter;
  import updown_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         mrn, sclr, noload, en, dn, ci;
  logic [W-1:0] d, max;
  logic [W-1:0] q_w, q_s;
  logic         co_w, bo_w, sat_w, tc_w;
  logic         co_s, bo_s, sat_s, tc_s;

  logic         c_sclr, c_en;
  logic [W-1:0] q_lo, q_hi;
  logic         co_lo, bo_lo, sat_lo, tc_lo;
  logic         co_hi, bo_hi, sat_hi, tc_hi;

  int errors = 0;
  int checks = 0;
  bit compare_on = 1'b0;

  updown_mod_counter #(.WIDTH(W), .SATURATE(MODE_WRAP)) dut_wrap (
    .CLK(clk), .MRn(mrn), .SCLR(sclr), .NoLoad(noload), .EN(en), .Dn(dn), .CI(ci),
    .D(d), .MAX(max), .Q(q_w), .CO(co_w), .BO(bo_w), .SAT(sat_w), .TC(tc_w)
  );

  updown_mod_counter #(.WIDTH(W), .SATURATE(MODE_SAT)) dut_sat (
    .CLK(clk), .MRn(mrn), .SCLR(sclr), .NoLoad(noload), .EN(en), .Dn(dn), .CI(ci),
    .D(d), .MAX(max), .Q(q_s), .CO(co_s), .BO(bo_s), .SAT(sat_s), .TC(tc_s)
  );

  updown_mod_counter #(.WIDTH(W), .SATURATE(MODE_WRAP)) dut_lo (
    .CLK(clk), .MRn(mrn), .SCLR(c_sclr), .NoLoad(1'b1), .EN(c_en), .Dn(1'b0), .CI(1'b1),
    .D(8'd0), .MAX(8'd9), .Q(q_lo), .CO(co_lo), .BO(bo_lo), .SAT(sat_lo), .TC(tc_lo)
  );

  updown_mod_counter #(.WIDTH(W), .SATURATE(MODE_WRAP)) dut_hi (
    .CLK(clk), .MRn(mrn), .SCLR(c_sclr), .NoLoad(1'b1), .EN(c_en), .Dn(1'b0), .CI(tc_lo),
    .D(8'd0), .MAX(8'd9), .Q(q_hi), .CO(co_hi), .BO(bo_hi), .SAT(sat_hi), .TC(tc_hi)
  );

  typedef struct {
    int q;
    bit co;
    bit bo;
    bit sat;
  } mstate_t;

  mstate_t m_w = '{0, 0, 0, 0};
  mstate_t m_s = '{0, 0, 0, 0};

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from the counter's rules, in plain integer arithmetic.
  function automatic mstate_t next_state(input mstate_t s, input bit hold_at_limit);
    mstate_t n;
    int lim;
    lim = int'(max);
    n = '{s.q, 0, 0, 0};
    if (sclr) n.q = 0;
    else if (!noload) n.q = int'(d);
    else if (en && ci) begin
      if (!dn) begin
        if (s.q >= lim) begin
          if (hold_at_limit) begin n.q = lim; n.sat = 1; end
          else begin n.q = 0; n.co = 1; end
        end else n.q = s.q + 1;
      end else begin
        if (s.q == 0) begin
          if (hold_at_limit) n.sat = 1;
          else begin n.q = lim; n.bo = 1; end
        end else n.q = s.q - 1;
      end
    end
    return n;
  endfunction

  function automatic bit expected_tc(input int q);
    return en && ci && (dn ? (q == 0) : (q >= int'(max)));
  endfunction

  always @(posedge clk or negedge mrn) begin
    if (!mrn) begin
      m_w <= '{0, 0, 0, 0};
      m_s <= '{0, 0, 0, 0};
    end else begin
      m_w <= next_state(m_w, 1'b0);
      m_s <= next_state(m_s, 1'b1);
    end
  end

  always @(negedge clk) begin
    if (compare_on) begin
      check_output("model_q_wrap",   q_w,   m_w.q);
      check_output("model_co_wrap",  co_w,  m_w.co);
      check_output("model_bo_wrap",  bo_w,  m_w.bo);
      check_output("model_sat_wrap", sat_w, m_w.sat);
      check_output("model_tc_wrap",  tc_w,  expected_tc(m_w.q));
      check_output("model_q_sat",    q_s,   m_s.q);
      check_output("model_co_sat",   co_s,  m_s.co);
      check_output("model_bo_sat",   bo_s,  m_s.bo);
      check_output("model_sat_sat",  sat_s, m_s.sat);
      check_output("model_tc_sat",   tc_s,  expected_tc(m_s.q));
    end
  end

  task automatic apply_stimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mrn = 1'b0; sclr = 1'b0; noload = 1'b1; en = 1'b0; dn = 1'b0; ci = 1'b1;
    d = '0; max = 8'd9; c_sclr = 1'b0; c_en = 1'b0;
    repeat (2) apply_stimulus();
    check_output("reset_q", q_w, 0);
    check_output("reset_co", co_w, 0);
    mrn = 1'b1;
    compare_on = 1'b1;

    // Asynchronous reset mid-count at 0x37
    max = 8'd200; d = 8'h30; noload = 1'b0;
    apply_stimulus();
    noload = 1'b1; en = 1'b1;
    repeat (7) apply_stimulus();
    en = 1'b0;
    check_output("pre_reset_q", q_w, 8'h37);
    @(posedge clk);
    #3;
    mrn = 1'b0;
    #1;
    check_output("async_reset_q", q_w, 0);
    check_output("async_reset_q_sat", q_s, 0);
    apply_stimulus();
    mrn = 1'b1;

    // Up-wrap at MAX=9
    max = 8'd9; sclr = 1'b1;
    apply_stimulus();
    sclr = 1'b0; en = 1'b1; dn = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      apply_stimulus();
      check_output("upwrap_q", q_w, i % 10);
      check_output("upwrap_co", co_w, (i == 10));
      if (i == 9) check_output("upwrap_tc", tc_w, 1);
    end

    // Down-wrap from 0
    noload = 1'b0; d = 8'd0; en = 1'b0;
    apply_stimulus();
    noload = 1'b1; en = 1'b1; dn = 1'b1;
    apply_stimulus();
    check_output("downwrap_q", q_w, 9);
    check_output("downwrap_bo", bo_w, 1);
    en = 1'b0;
    apply_stimulus();
    check_output("hold_q", q_w, 9);
    check_output("hold_bo", bo_w, 0);

    // Saturation at MAX=200
    max = 8'd200; d = 8'd199; noload = 1'b0;
    apply_stimulus();
    noload = 1'b1; en = 1'b1; dn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus();
      check_output("sat_q", q_s, 200);
      check_output("sat_flag", sat_s, (i > 0));
      check_output("sat_co", co_s, 0);
    end

    // Priority, out-of-range load, recovery
    max = 8'd9; sclr = 1'b1; noload = 1'b0; en = 1'b1; d = 8'h55;
    apply_stimulus();
    check_output("prio_q", q_w, 0);
    sclr = 1'b0; d = 8'hF0;
    apply_stimulus();
    check_output("oor_load_q", q_w, 8'hF0);
    noload = 1'b1;
    apply_stimulus();
    check_output("oor_up_q", q_w, 0);
    check_output("oor_up_co", co_w, 1);
    noload = 1'b0;
    apply_stimulus();
    noload = 1'b1; dn = 1'b1;
    apply_stimulus();
    check_output("oor_down_q", q_w, 8'hEF);
    check_output("oor_down_bo", bo_w, 0);

    // MAX=0 pulses on every step
    max = 8'd0; dn = 1'b0;
    apply_stimulus();
    apply_stimulus();
    check_output("max0_up_q", q_w, 0);
    check_output("max0_up_co", co_w, 1);
    dn = 1'b1;
    apply_stimulus();
    check_output("max0_dn_q", q_w, 0);
    check_output("max0_dn_bo", bo_w, 1);
    en = 1'b0;

    // Two-stage decimal cascade 00..99 -> 00
    c_sclr = 1'b1;
    apply_stimulus();
    c_sclr = 1'b0; c_en = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      apply_stimulus();
      check_output("casc_lo", q_lo, i % 10);
      check_output("casc_hi", q_hi, (i / 10) % 10);
      check_output("casc_hi_co", co_hi, (i == 100));
    end
    c_en = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      mrn    = ($urandom_range(0, 99) != 0);
      sclr   = ($urandom_range(0, 15) == 0);
      noload = ($urandom_range(0, 7) != 0);
      en     = ($urandom_range(0, 3) != 0);
      ci     = ($urandom_range(0, 3) != 0);
      dn     = 1'($urandom_range(0, 1));
      d      = W'($urandom);
      if ($urandom_range(0, 9) == 0)
        max = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 15));
      apply_stimulus();
    end

    compare_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 The block SHALL have parameter SATURATE, default 0: 0 means wrap at the limits, 1 means hold at the limits.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 MRn  input  1  asynchronous active-low master reset.
REQ-006 SCLR  input  1  synchronous clear, active-high.
REQ-007 NoLoad  input  1  active-low synchronous load of D.
REQ-008 EN  input  1  count enable.
REQ-009 Dn  input  1  direction: 0 counts up, 1 counts down.
REQ-010 CI  input  1  cascade enable from a lower stage; the counter steps only when EN=1 and CI=1.
REQ-011 D  input  WIDTH  load value.
REQ-012 MAX  input  WIDTH  terminal value; the count range is 0..MAX, giving modulus MAX+1.
REQ-013 Q  output  WIDTH  registered count.
REQ-014 CO  output  1  registered carry: one-cycle pulse on an up-wrap.
REQ-015 BO  output  1  registered borrow: one-cycle pulse on a down-wrap.
REQ-016 SAT  output  1  registered flag: a step was blocked at a limit (SATURATE=1 only).
REQ-017 TC  output  1  combinational terminal count for the next stage: EN & CI & (Dn ? Q==0 : Q>=MAX).

Function
REQ-018 Per-edge priority SHALL be: SCLR, then load (NoLoad=0), then step (EN&CI=1), then hold.
REQ-019 SCLR=1 SHALL set Q=0 and CO=BO=SAT=0.
REQ-020 Load SHALL set Q=D unmodified, even if D>MAX, and SHALL clear CO, BO and SAT.
REQ-021 Up step with Q<MAX SHALL set Q=Q+1 and CO=0.
REQ-022 Up step with Q>=MAX and SATURATE=0 SHALL set Q=0 and CO=1.
REQ-023 Up step with Q>=MAX and SATURATE=1 SHALL set Q=MAX and SAT=1, with CO=0.
REQ-024 Down step with Q>0 SHALL set Q=Q-1 and BO=0.
REQ-025 Down step with Q=0 and SATURATE=0 SHALL set Q=MAX and BO=1.
REQ-026 Down step with Q=0 and SATURATE=1 SHALL set Q=0 and SAT=1, with BO=0.
REQ-027 A down step from Q>MAX (after an out-of-range load) SHALL decrement normally.
REQ-028 CO, BO and SAT SHALL be single-cycle: any edge that is not the triggering step clears them, including hold edges.
REQ-029 MAX=0 SHALL keep Q at 0; every up step pulses CO and every down step pulses BO (SATURATE=0).
REQ-030 A change of MAX mid-count SHALL take effect at the next edge with no other side effect.
REQ-031 Arithmetic SHALL be modulo 2^WIDTH internally; no overflow beyond WIDTH bits is possible.
REQ-032 Latency SHALL be one clock from inputs to Q, CO, BO and SAT; TC SHALL have zero latency.

Reset
REQ-033 MRn=0 SHALL asynchronously force Q=0, CO=0, BO=0 and SAT=0, overriding all other inputs.
REQ-034 Reset release SHALL take effect at the first rising edge after MRn=1, and resetting mid-count SHALL discard all state.

Structure
REQ-035 The direction encodings (UP=0, DN=1) and mode constants (WRAP=0, SAT=1) SHALL reside in the shared package updown_pkg.
REQ-036 The block SHALL be a single module; no sub-module is required, and TC is inline logic.

Verification (WIDTH=8)
REQ-037 Reset: MRn=0 asserted asynchronously mid-count at Q=0x37 -> Q=0 immediately, without waiting for a clock edge.
REQ-038 Up-wrap: MAX=9, SATURATE=0, count up from 0 for 10 steps -> Q goes 1..9 then 0, CO=1 only on the 0 edge, and TC=1 while Q=9.
REQ-039 Down-wrap: MAX=9, load 0, one down step -> Q=9 and BO=1; the next hold edge -> BO=0.
REQ-040 Saturate: SATURATE=1, MAX=200, load 199, three up steps -> Q=200,200,200 and SAT=0,1,1; CO never asserts.
REQ-041 Priority: SCLR=1, NoLoad=0 and EN=1 on the same edge -> Q=0; then NoLoad=0 with D=0xF0 (>MAX=9) -> Q=0xF0, and one up step -> Q=0 with CO=1.
REQ-042 Cascade: two instances, with the low stage's TC driving the high stage's CI, MAX=9 each -> the pair counts 00..99 in decimal and wraps to 00 with the high stage's CO=1.
